// File: rtl/hazard_pkg.sv
// Shared types for the pipeline hazard controller: FSM state encoding,
// register-address width and a saturating counter helper.
package hazard_pkg;

   localparam int REG_ADD_W = 5;

   typedef enum logic [1:0] {
      ST_RUN        = 2'd0,
      ST_LOAD_STALL = 2'd1,
      ST_FLUSH      = 2'd2,
      ST_MEM_WAIT   = 2'd3
   } haz_state_e;

   function automatic logic [7:0] sat_inc8(input logic [7:0] val);
      return (val == 8'hFF) ? val : val + 8'd1;
   endfunction

endpackage

// File: rtl/pipeline_hazard_ctrl_if.sv
// Hazard-control bundle between the pipeline datapath (master) and the
// hazard controller (slave).
interface pipeline_hazard_ctrl_if;
   import hazard_pkg::*;

   logic                 id_valid_i;
   logic [REG_ADD_W-1:0] id_rs1_add_i;
   logic [REG_ADD_W-1:0] id_rs2_add_i;
   logic [REG_ADD_W-1:0] ex_rd_add_i;
   logic                 ex_RD_en_i;
   logic                 ex_redirect_i;
   logic                 mem_busy_i;
   logic                 pc_hold_o;
   logic                 if_stall_o;
   logic                 id_stall_o;
   logic                 id_flush_o;
   logic                 if_flush_o;
   logic                 mem_freeze_o;
   logic                 err_timeout_o;

   modport master (
      output id_valid_i, id_rs1_add_i, id_rs2_add_i, ex_rd_add_i,
             ex_RD_en_i, ex_redirect_i, mem_busy_i,
      input  pc_hold_o, if_stall_o, id_stall_o, id_flush_o, if_flush_o,
             mem_freeze_o, err_timeout_o
   );

   modport slave (
      input  id_valid_i, id_rs1_add_i, id_rs2_add_i, ex_rd_add_i,
             ex_RD_en_i, ex_redirect_i, mem_busy_i,
      output pc_hold_o, if_stall_o, id_stall_o, id_flush_o, if_flush_o,
             mem_freeze_o, err_timeout_o
   );

endinterface

// File: rtl/hazard_load_use_det.sv
// Load-use detector: a load in EX writes a register that the valid ID
// instruction reads. x0 is never a hazard.
module hazard_load_use_det
   import hazard_pkg::*;
(
   input  logic                 id_valid_i,
   input  logic [REG_ADD_W-1:0] id_rs1_add_i,
   input  logic [REG_ADD_W-1:0] id_rs2_add_i,
   input  logic [REG_ADD_W-1:0] ex_rd_add_i,
   input  logic                 ex_ld_i,
   output logic                 load_use_o
);

   assign load_use_o = id_valid_i & ex_ld_i & (|ex_rd_add_i)
                     & ((ex_rd_add_i == id_rs1_add_i) | (ex_rd_add_i == id_rs2_add_i));

endmodule

// File: rtl/pipeline_hazard_ctrl.sv
// Stall/flush sequencer around the decode stage with a memory-wait watchdog.
// Optional HAZ_PERF_CNT_EN adds stall/flush cycle counters as extra ports.
//
//   state       | meaning
//   RUN         | normal flow; hazards dispatched by priority busy > redirect > load-use
//   LOAD_STALL  | the single bubble after a load-use stall; load-use masked
//   FLUSH       | redirect bubbles while fcnt > 0; fcnt == 0 behaves like RUN
//   MEM_WAIT    | data memory busy; pipe frozen, watchdog counting
module pipeline_hazard_ctrl
   import hazard_pkg::*;
#(
   parameter int FLUSH_CYCLES = 1,
   parameter int MAX_MEM_WAIT = 15
`ifdef HAZ_PERF_CNT_EN
   , parameter int CNT_W = 32
`endif
) (
   input  logic                  clk,
   input  logic                  rst_n,
   pipeline_hazard_ctrl_if.slave hif
`ifdef HAZ_PERF_CNT_EN
   , output logic [CNT_W-1:0]    stall_cnt_o
   , output logic [CNT_W-1:0]    flush_cnt_o
`endif
);

   localparam logic [2:0] FCNT_LOAD = 3'(FLUSH_CYCLES - 1);
   localparam logic [7:0] WCNT_MAX  = 8'(MAX_MEM_WAIT);

   haz_state_e state_q, state_d;
   logic [2:0] fcnt_q, fcnt_d;
   logic [7:0] wcnt_q, wcnt_d;
   logic       err_q, err_d;
   logic       load_use;
   logic       stall_v, freeze_v, flush_v;

   hazard_load_use_det u_lu_det (
      .id_valid_i   (hif.id_valid_i),
      .id_rs1_add_i (hif.id_rs1_add_i),
      .id_rs2_add_i (hif.id_rs2_add_i),
      .ex_rd_add_i  (hif.ex_rd_add_i),
      .ex_ld_i      (hif.ex_RD_en_i),
      .load_use_o   (load_use)
   );

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= ST_RUN;
         fcnt_q  <= '0;
         wcnt_q  <= '0;
         err_q   <= 1'b0;
      end else begin
         state_q <= state_d;
         fcnt_q  <= fcnt_d;
         wcnt_q  <= wcnt_d;
         err_q   <= err_d;
      end
   end

   always_comb begin
      state_d  = state_q;
      fcnt_d   = fcnt_q;
      wcnt_d   = wcnt_q;
      err_d    = err_q;
      stall_v  = 1'b0;
      freeze_v = 1'b0;
      flush_v  = 1'b0;
      unique case (state_q)
         ST_MEM_WAIT: begin
            // Redirects are ignored here; the frozen EX stage re-presents them on exit.
            if (hif.mem_busy_i) begin
               stall_v  = 1'b1;
               freeze_v = 1'b1;
               if (wcnt_q == WCNT_MAX) begin
                  err_d   = 1'b1;
                  state_d = ST_RUN;
               end else begin
                  wcnt_d = sat_inc8(wcnt_q);
               end
            end else begin
               state_d = ST_RUN;
            end
         end
         default: begin
            if (hif.mem_busy_i) begin
               stall_v  = 1'b1;
               freeze_v = 1'b1;
               wcnt_d   = '0;
               state_d  = ST_MEM_WAIT;
            end else if (hif.ex_redirect_i) begin
               flush_v = 1'b1;
               fcnt_d  = FCNT_LOAD;
               state_d = ST_FLUSH;
            end else if (state_q == ST_FLUSH && fcnt_q != 3'd0) begin
               flush_v = 1'b1;
               fcnt_d  = fcnt_q - 3'd1;
            end else if (load_use && state_q != ST_LOAD_STALL) begin
               stall_v = 1'b1;
               state_d = ST_LOAD_STALL;
            end else begin
               state_d = ST_RUN;
            end
         end
      endcase
   end

   // Gated by rst_n so every output is 0 while reset is held, whatever the inputs do.
   assign hif.pc_hold_o     = rst_n & stall_v;
   assign hif.if_stall_o    = rst_n & stall_v;
   assign hif.id_stall_o    = rst_n & stall_v;
   assign hif.mem_freeze_o  = rst_n & freeze_v;
   assign hif.id_flush_o    = rst_n & flush_v;
   assign hif.if_flush_o    = rst_n & flush_v;
   assign hif.err_timeout_o = err_q;

`ifdef HAZ_PERF_CNT_EN
   logic [CNT_W-1:0] stall_cnt_q, stall_cnt_d;
   logic [CNT_W-1:0] flush_cnt_q, flush_cnt_d;

   always_comb begin
      stall_cnt_d = stall_cnt_q + (hif.pc_hold_o  ? CNT_W'(1) : '0);
      flush_cnt_d = flush_cnt_q + (hif.id_flush_o ? CNT_W'(1) : '0);
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         stall_cnt_q <= '0;
         flush_cnt_q <= '0;
      end else begin
         stall_cnt_q <= stall_cnt_d;
         flush_cnt_q <= flush_cnt_d;
      end
   end

   assign stall_cnt_o = stall_cnt_q;
   assign flush_cnt_o = flush_cnt_q;
`endif

endmodule
